exec_ctrl: RTL and testbench

EXEC_CTRL -- requirements
Module: exec_ctrl

---
 rtl/exec_ctrl_if.sv | 24 ++
 rtl/exec_ctrl.sv | 92 +++++++++
 tb/tb_exec_ctrl.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/exec_ctrl_if.sv
// Fetch and register-file bus of the exec_ctrl accumulator sequencer.
// master is the controller side, slave is the memory/register-file side.
interface exec_ctrl_if;
  logic [5:0] pc;
  logic [5:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] reg_addr;
  logic [5:0] reg_data;
  logic       write_reg;
  logic [5:0] x8;
  logic       zero;
  logic       carry;
  logic       halted;

  modport master (
    output pc, instr_ready, reg_addr, write_reg, x8, zero, carry, halted,
    input  instr, instr_valid, reg_data
  );
  modport slave (
    input  pc, instr_ready, reg_addr, write_reg, x8, zero, carry, halted,
    output instr, instr_valid, reg_data
  );
endinterface

// File: rtl/exec_ctrl.sv
// Two-phase (FETCH/EXEC) accumulator sequencer with a 6-bit pc, one accumulator
// x8 and a carry flag; HALT is sticky until reset.
module exec_ctrl (
  input  logic         clk,
  input  logic         reset,
  exec_ctrl_if.master  bus
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LI  = 3'd1;
  localparam logic [2:0] OP_LD  = 3'd2;
  localparam logic [2:0] OP_ST  = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_BNZ = 3'd7;

  logic [1:0] state;
  logic [5:0] pc;
  logic [5:0] ir;
  logic [5:0] x8;
  logic       carry;
  logic [2:0] op;
  logic [2:0] opr;
  logic [6:0] sum;

  assign op  = ir[5:3];
  assign opr = ir[2:0];
  assign sum = {1'b0, x8} + {1'b0, bus.reg_data};

  // Handshake outputs also look at reset directly so they react without a clock.
  assign bus.instr_ready = reset || (state == FETCH);
  assign bus.write_reg   = !reset && (state == EXEC) && (op == OP_ST);
  assign bus.halted      = (state == HALT);
  assign bus.reg_addr    = opr;
  assign bus.pc          = pc;
  assign bus.x8          = x8;
  assign bus.zero        = (x8 == 6'd0);
  assign bus.carry       = carry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= 6'd0;
      ir    <= 6'd0;
      x8    <= 6'd0;
      carry <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.instr_valid) begin
            ir    <= bus.instr;
            state <= EXEC;
          end
        end
        EXEC: begin
          state <= FETCH;
          pc    <= pc + 6'd1;
          case (op)
            OP_NOP: begin
              if (opr == 3'd7) begin
                state <= HALT;
                pc    <= pc;
              end
            end
            OP_LI:  x8 <= {3'b000, opr};
            OP_LD:  x8 <= bus.reg_data;
            OP_ST:  ;
            OP_ADD: {carry, x8} <= sum;
            OP_SUB: begin
              x8    <= x8 - bus.reg_data;
              carry <= (bus.reg_data > x8);
            end
            OP_XOR: begin
              x8    <= x8 ^ bus.reg_data;
              carry <= 1'b0;
            end
            OP_BNZ: begin
              // operand 0 with x8 != 0 re-fetches the same BNZ forever
              if (x8 != 6'd0) pc <= pc - {3'b000, opr};
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: instruction ROM indexed by pc and a register
// file written on the falling edge, expected values hand-computed.
module tb_exec_ctrl;
  logic clk;
  logic reset;
  logic [5:0] imem [64];
  logic [5:0] rf   [8];
  logic       ivalid;
  int n_cmp;
  int n_err;

  exec_ctrl_if bus ();
  exec_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.instr       = imem[bus.pc];
  assign bus.instr_valid = ivalid;
  assign bus.reg_data    = rf[bus.reg_addr];

  always @(negedge clk) if (bus.write_reg) rf[bus.reg_addr] <= bus.x8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, exp);
      $error("%s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 6'b000_000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [5:0] exp_pc [8];
    n_cmp = 0;
    n_err = 0;
    ivalid = 1'b1;
    reset = 1'b1;
    clear_imem();
    for (int i = 0; i < 8; i++) rf[i] = 6'd0;
    rf[1] = 6'd60; rf[2] = 6'd10; rf[4] = 6'd7; rf[5] = 6'd1;
    #3;
    chk("rst_pc", bus.pc, 0);
    chk("rst_x8", bus.x8, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_halted", bus.halted, 0);
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_wr", bus.write_reg, 0);

    // load/store: LI 5; ST r3; LI 0; LD r3
    imem[0] = 6'b001_101; imem[1] = 6'b011_011; imem[2] = 6'b001_000; imem[3] = 6'b010_011;
    do_reset();
    chk("ls_f0_wr", bus.write_reg, 0);
    cyc(); chk("ls_e0_ready", bus.instr_ready, 0); chk("ls_e0_wr", bus.write_reg, 0);
    cyc(); chk("ls_f1_pc", bus.pc, 1); chk("ls_f1_x8", bus.x8, 5); chk("ls_f1_wr", bus.write_reg, 0);
    cyc(); chk("ls_st_wr", bus.write_reg, 1); chk("ls_st_addr", bus.reg_addr, 3); chk("ls_st_x8", bus.x8, 5);
    cyc(); chk("ls_f2_wr", bus.write_reg, 0); chk("ls_rf3", rf[3], 5); chk("ls_f2_pc", bus.pc, 2);
    cyc(); chk("ls_e2_wr", bus.write_reg, 0);
    cyc(); chk("ls_f3_x8", bus.x8, 0); chk("ls_f3_zero", bus.zero, 1);
    cyc(); chk("ls_e3_wr", bus.write_reg, 0);
    cyc(); chk("ls_end_x8", bus.x8, 5); chk("ls_end_zero", bus.zero, 0); chk("ls_end_pc", bus.pc, 4);

    // ADD overflow then SUB borrow, carry held by LI
    clear_imem();
    imem[0] = 6'b010_001; imem[1] = 6'b100_010; imem[2] = 6'b101_100; imem[3] = 6'b001_010;
    do_reset();
    cyc(); cyc(); chk("add_ld_x8", bus.x8, 60); chk("add_ld_carry", bus.carry, 0);
    cyc(); cyc(); chk("add_x8", bus.x8, 6); chk("add_carry", bus.carry, 1);
    cyc(); cyc(); chk("sub_x8", bus.x8, 63); chk("sub_carry", bus.carry, 1);
    cyc(); cyc(); chk("li_x8", bus.x8, 2); chk("li_carry_held", bus.carry, 1);

    // countdown loop: LI 3; SUB r5(=1); BNZ 1; NOP
    clear_imem();
    imem[0] = 6'b001_011; imem[1] = 6'b101_101; imem[2] = 6'b111_001;
    exp_pc[0] = 0; exp_pc[1] = 1; exp_pc[2] = 2; exp_pc[3] = 1;
    exp_pc[4] = 2; exp_pc[5] = 1; exp_pc[6] = 2; exp_pc[7] = 3;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("loop_pc%0d", i), bus.pc, exp_pc[i]);
      if (i < 7) begin cyc(); cyc(); end
    end
    chk("loop_x8", bus.x8, 0);
    chk("loop_zero", bus.zero, 1);
    chk("loop_carry", bus.carry, 0);

    // fetch stall at pc=3 for 4 cycles, accept on the 5th
    ivalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("stall_pc%0d", i), bus.pc, 3);
      chk($sformatf("stall_x8_%0d", i), bus.x8, 0);
      chk($sformatf("stall_ready%0d", i), bus.instr_ready, 1);
    end
    ivalid = 1'b1;
    cyc(); chk("stall_accept", bus.instr_ready, 0);
    cyc(); chk("stall_next_pc", bus.pc, 4);

    // reset during ST EXEC abandons the store
    clear_imem();
    imem[0] = 6'b011_010;
    do_reset();
    cyc(); chk("rst_st_wr_hi", bus.write_reg, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_st_wr_lo", bus.write_reg, 0);
    chk("rst_st_pc", bus.pc, 0);
    chk("rst_st_rf2", rf[2], 10);

    // HALT at pc=9, then asynchronous reset mid-cycle
    clear_imem();
    imem[9] = 6'b000_111;
    do_reset();
    repeat (18) cyc();
    chk("halt_f_pc", bus.pc, 9);
    cyc(); chk("halt_exec_halted", bus.halted, 0);
    cyc();
    for (int i = 0; i < 11; i++) begin
      chk($sformatf("halt_pc%0d", i), bus.pc, 9);
      chk($sformatf("halt_h%0d", i), bus.halted, 1);
      chk($sformatf("halt_rdy%0d", i), bus.instr_ready, 0);
      cyc();
    end
    #2 reset = 1'b1;
    #1;
    chk("halt_rst_halted", bus.halted, 0);
    chk("halt_rst_pc", bus.pc, 0);
    chk("halt_rst_ready", bus.instr_ready, 1);

    // pc wrap: NOP at 63 -> 0
    clear_imem();
    do_reset();
    repeat (126) cyc();
    chk("wrap_pc63", bus.pc, 63);
    cyc(); cyc();
    chk("wrap_pc0", bus.pc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
